nx_stream_distributor: RTL

- Outbound counterpart to the node's inbound stream arbiter.
- Accepts two sources:
  - the bypass stream from the arbiter, which carries its own direction;
  - the node's locally emitted message stream, whose direction this block computes.
- Steers each message onto one of four registered outbound mesh streams (N/E/S/W).
- Arbitrates fairly when both sources target the same direction in the same cycle.

---
 rtl/nx_constants.sv | 51 +++++
 rtl/nx_distrib_slot.sv | 91 +++++++++
 rtl/nx_stream_distributor.sv | 118 +++++++++++
 3 files changed

// File: rtl/nx_constants.sv
// Shared mesh-node types: message layout, directions, route helper.
// Also holds the distributor's arbitration source encoding.
package nx_constants;

    localparam int NX_ROW_W     = 4;
    localparam int NX_COL_W     = 4;
    localparam int NX_PAYLOAD_W = 24;
    localparam int NX_NUM_DIRS  = 4;

    typedef struct packed {
        logic [NX_ROW_W-1:0] row;
        logic [NX_COL_W-1:0] col;
    } nx_header_t;

    typedef struct packed {
        nx_header_t              header;
        logic [NX_PAYLOAD_W-1:0] payload;
    } nx_message_t;

    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_EAST  = 2'd1,
        DIR_SOUTH = 2'd2,
        DIR_WEST  = 2'd3
    } nx_direction_t;

    typedef enum logic {
        BYPASS = 1'b0,
        EMIT   = 1'b1
    } nx_distrib_src_t;

    // Row is resolved before column; a self-addressed message falls to WEST.
    function automatic nx_direction_t nx_route_dir(
        input nx_header_t          hdr,
        input logic [NX_ROW_W-1:0] row,
        input logic [NX_COL_W-1:0] col
    );
        nx_direction_t dir;
        if (hdr.row > row) begin
            dir = DIR_SOUTH;
        end else if (hdr.row < row) begin
            dir = DIR_NORTH;
        end else if (hdr.col > col) begin
            dir = DIR_EAST;
        end else begin
            dir = DIR_WEST;
        end
        return dir;
    endfunction

endpackage

// File: rtl/nx_distrib_slot.sv
// One outbound direction slot: single register, or a 2-entry FIFO
// when NX_DISTRIB_FIFO_EN is defined.
module nx_distrib_slot
    import nx_constants::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  nx_message_t push_data_i,
    output logic        free_o,
    output logic        valid_o,
    output nx_message_t data_o,
    input  logic        ready_i
);

`ifdef NX_DISTRIB_FIFO_EN

    logic [1:0]  count_q, count_d;
    nx_message_t e0_q, e0_d;
    nx_message_t e1_q, e1_d;
    logic        pop;

    assign pop     = ready_i && (count_q != 2'd0);
    assign free_o  = (count_q != 2'd2) || ready_i;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = e0_q;

    // Pop shifts first, then the push lands in the first empty entry.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (pop) begin
            e0_d    = e1_q;
            count_d = count_d - 2'd1;
        end
        if (push_i) begin
            if (count_d == 2'd0) begin
                e0_d = push_data_i;
            end else begin
                e1_d = push_data_i;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

`else

    logic        valid_q, valid_d;
    nx_message_t data_q, data_d;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`endif

endmodule

// File: rtl/nx_stream_distributor.sv
// Steers bypass and locally emitted messages onto four outbound mesh
// streams with round-robin fairness; NX_DISTRIB_FIFO_EN deepens slots.
module nx_stream_distributor
    import nx_constants::*;
#(
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    input  nx_message_t               bypass_data_i,
    input  nx_direction_t             bypass_dir_i,
    input  logic                      bypass_valid_i,
    output logic                      bypass_ready_o,
    input  nx_message_t               emit_data_i,
    input  logic                      emit_valid_i,
    output logic                      emit_ready_o,
    output nx_message_t               north_data_o,
    output nx_message_t               east_data_o,
    output nx_message_t               south_data_o,
    output nx_message_t               west_data_o,
    output logic                      north_valid_o,
    output logic                      east_valid_o,
    output logic                      south_valid_o,
    output logic                      west_valid_o,
    input  logic                      north_ready_i,
    input  logic                      east_ready_i,
    input  logic                      south_ready_i,
    input  logic                      west_ready_i
);

    nx_direction_t   emit_dir;
    nx_distrib_src_t rr_q, rr_d;

    logic [3:0]  free;
    logic [3:0]  push;
    logic [3:0]  ready;
    logic [3:0]  valid;
    logic [3:0]  b_sel;
    logic [3:0]  e_sel;
    nx_message_t push_data [NX_NUM_DIRS];
    nx_message_t data      [NX_NUM_DIRS];

    logic same_dir;
    logic conflict;
    logic b_fire;
    logic e_fire;

    assign emit_dir = nx_route_dir(emit_data_i.header,
                                   NX_ROW_W'(node_row_i),
                                   NX_COL_W'(node_col_i));

    assign same_dir = (bypass_dir_i == emit_dir);
    assign conflict = bypass_valid_i && emit_valid_i && same_dir;

    // Each ready looks only at the other source's valid, never its own.
    assign bypass_ready_o = free[bypass_dir_i] &&
                            (!(emit_valid_i && same_dir) || rr_q == BYPASS);
    assign emit_ready_o   = free[emit_dir] &&
                            (!(bypass_valid_i && same_dir) || rr_q == EMIT);

    assign b_fire = bypass_valid_i && bypass_ready_o;
    assign e_fire = emit_valid_i && emit_ready_o;

    assign b_sel = 4'b0001 << bypass_dir_i;
    assign e_sel = 4'b0001 << emit_dir;

    assign push = (b_fire ? b_sel : 4'b0000) | (e_fire ? e_sel : 4'b0000);

    always_comb begin
        for (int d = 0; d < NX_NUM_DIRS; d++) begin
            push_data[d] = (b_fire && b_sel[d]) ? bypass_data_i : emit_data_i;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (conflict && (b_fire || e_fire)) begin
            rr_d = (rr_q == BYPASS) ? EMIT : BYPASS;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= BYPASS;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign ready = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};

    for (genvar d = 0; d < NX_NUM_DIRS; d++) begin : g_slot
        nx_distrib_slot u_slot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (push[d]),
            .push_data_i (push_data[d]),
            .free_o      (free[d]),
            .valid_o     (valid[d]),
            .data_o      (data[d]),
            .ready_i     (ready[d])
        );
    end

    assign north_valid_o = valid[DIR_NORTH];
    assign east_valid_o  = valid[DIR_EAST];
    assign south_valid_o = valid[DIR_SOUTH];
    assign west_valid_o  = valid[DIR_WEST];

    assign north_data_o = data[DIR_NORTH];
    assign east_data_o  = data[DIR_EAST];
    assign south_data_o = data[DIR_SOUTH];
    assign west_data_o  = data[DIR_WEST];

endmodule
